// File: rtl/ps2_packet_ctrl.sv
// PS/2 mouse packet controller: aligns the received byte stream into 3-byte
// packets, abandons stalled partials on timeout and buffers packets in a FIFO.
module ps2_packet_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DEPTH          = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [23:0] pkt_data,
  output logic        overflow,
  input  logic        clr_overflow,
  output logic        resync,
  output logic [15:0] pkt_count
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PTR_ONE   = CNT_W'(1);
  localparam logic [15:0]      TO_LIMIT  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } state_t;

  state_t            r_state;
  logic [7:0]        r_b1;
  logic [7:0]        r_b2;
  logic [15:0]       r_idle;
  logic              r_resync;

  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [23:0]       r_mem [DEPTH];
  logic              r_overflow;
  logic [15:0]       r_pkt_count;

  logic [15:0]       w_idle_inc;
  logic              w_timeout;
  logic              w_push_try;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_pop;
  logic              w_full;
  logic              w_valid;
  logic [CNT_W-1:0]  w_occupancy;
  logic [23:0]       w_pkt;

  assign w_idle_inc = r_idle + 16'd1;
  assign w_timeout  = !in_valid && (w_idle_inc == TO_LIMIT);

  // Packet assembly and inter-byte timeout. A byte arriving on the would-be
  // timeout cycle is taken, because the in_valid branches are tested first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: every register that holds state is written with <= so all of
      // them update together from values sampled before the edge.
      r_state  <= SEEK;
      r_b1     <= 8'd0;
      r_b2     <= 8'd0;
      r_idle   <= 16'd0;
      r_resync <= 1'b0;
    end else begin
      r_resync <= 1'b0;
      case (r_state)
        SEEK: begin
          r_idle <= 16'd0;
          if (in_valid && in_byte[3]) begin
            r_b1    <= in_byte;
            r_state <= GOT1;
          end
        end
        GOT1: begin
          if (in_valid) begin
            r_b2    <= in_byte;
            r_idle  <= 16'd0;
            r_state <= GOT2;
          end else if (w_timeout) begin
            r_idle   <= 16'd0;
            r_resync <= 1'b1;
            r_state  <= SEEK;
          end else begin
            r_idle <= w_idle_inc;
          end
        end
        GOT2: begin
          if (in_valid) begin
            r_idle  <= 16'd0;
            r_state <= SEEK;
          end else if (w_timeout) begin
            r_idle   <= 16'd0;
            r_resync <= 1'b1;
            r_state  <= SEEK;
          end else begin
            r_idle <= w_idle_inc;
          end
        end
        default: begin
          r_idle  <= 16'd0;
          r_state <= SEEK;
        end
      endcase
    end
  end

  assign w_pkt       = {r_b1, r_b2, in_byte};
  assign w_occupancy = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_occupancy == FULL_CNT);
  assign w_valid     = (w_occupancy != '0);
  assign w_pop       = w_valid && pkt_ready;
  assign w_push_try  = (r_state == GOT2) && in_valid;
  // A full FIFO still accepts the packet when the head leaves on the same edge.
  assign w_push_ok   = w_push_try && (!w_full || w_pop);
  assign w_drop      = w_push_try && !w_push_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_pkt_count <= 16'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr    <= r_wr_ptr + PTR_ONE;
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // NOTE: packet storage has no reset; the output mux below forces pkt_data to
  // zero whenever the FIFO is empty, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_pkt;
    end
  end

  assign pkt_valid = w_valid;
  assign pkt_data  = w_valid ? r_mem[r_rd_ptr[ADDR_W-1:0]] : 24'd0;
  assign overflow  = r_overflow;
  assign resync    = r_resync;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_ps2_packet_ctrl.sv
// Directed self-checking bench for ps2_packet_ctrl (TIMEOUT_CYCLES=4, DEPTH=2).
module tb_ps2_packet_ctrl;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [23:0] pkt_data;
  logic        overflow;
  logic        clr_overflow;
  logic        resync;
  logic [15:0] pkt_count;

  int checks;
  int failures;
  int resync_seen;

  ps2_packet_ctrl #(
    .TIMEOUT_CYCLES(4),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_byte(in_byte),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_data(pkt_data),
    .overflow(overflow),
    .clr_overflow(clr_overflow),
    .resync(resync),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (resync === 1'b1) resync_seen++;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    step();
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    in_valid     = 1'b0;
    in_byte      = 8'h00;
    pkt_ready    = 1'b0;
    clr_overflow = 1'b0;
    step();
    step();
    resetn = 1'b1;
    resync_seen = 0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    resync_seen = 0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_valid", 32'(pkt_valid), 32'd0);
    check("rst_data", 32'(pkt_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_resync", 32'(resync), 32'd0);
    check("rst_count", 32'(pkt_count), 32'd0);

    // 1. Basic packet, consumer always ready
    pkt_ready = 1'b1;
    send(8'h08);
    check("t1_valid_b1", 32'(pkt_valid), 32'd0);
    send(8'h12);
    send(8'h34);
    check("t1_valid", 32'(pkt_valid), 32'd1);
    check("t1_data", 32'(pkt_data), 32'h081234);
    check("t1_count", 32'(pkt_count), 32'd1);
    idle(1);
    check("t1_valid_after_pop", 32'(pkt_valid), 32'd0);
    check("t1_data_after_pop", 32'(pkt_data), 32'd0);

    // 2. Alignment: bytes without bit 3 are skipped in SEEK
    do_reset();
    send(8'h00);
    send(8'h07);
    send(8'h0C);
    send(8'hAA);
    check("t2_valid_before_b3", 32'(pkt_valid), 32'd0);
    send(8'hBB);
    check("t2_valid", 32'(pkt_valid), 32'd1);
    check("t2_data", 32'(pkt_data), 32'h0CAABB);
    check("t2_count", 32'(pkt_count), 32'd1);
    check("t2_no_resync", 32'(resync_seen), 32'd0);
    pkt_ready = 1'b1;
    idle(1);
    pkt_ready = 1'b0;
    check("t2_drained", 32'(pkt_valid), 32'd0);

    // 3. Backpressure and overflow
    do_reset();
    send(8'h08); send(8'h01); send(8'h02);
    check("t3_head_p1", 32'(pkt_data), 32'h080102);
    send(8'h08); send(8'h03); send(8'h04);
    check("t3_head_stable", 32'(pkt_data), 32'h080102);
    check("t3_no_ovf_yet", 32'(overflow), 32'd0);
    send(8'h08); send(8'h05); send(8'h06);
    check("t3_valid", 32'(pkt_valid), 32'd1);
    check("t3_head_after_drop", 32'(pkt_data), 32'h080102);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count", 32'(pkt_count), 32'd2);
    pkt_ready = 1'b1;
    idle(1);
    check("t3_pop1_data", 32'(pkt_data), 32'h080304);
    check("t3_pop1_valid", 32'(pkt_valid), 32'd1);
    idle(1);
    pkt_ready = 1'b0;
    check("t3_empty", 32'(pkt_valid), 32'd0);
    check("t3_empty_data", 32'(pkt_data), 32'd0);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("t3_ovf_cleared", 32'(overflow), 32'd0);

    // 4. Full FIFO, push coincides with pop
    send(8'h08); send(8'h11); send(8'h11);
    send(8'h08); send(8'h22); send(8'h22);
    check("t4_full_count", 32'(pkt_count), 32'd4);
    send(8'h08); send(8'h33);
    pkt_ready = 1'b1;
    send(8'h33);
    pkt_ready = 1'b0;
    check("t4_no_overflow", 32'(overflow), 32'd0);
    check("t4_count", 32'(pkt_count), 32'd5);
    check("t4_head", 32'(pkt_data), 32'h082222);
    pkt_ready = 1'b1;
    idle(1);
    check("t4_second", 32'(pkt_data), 32'h083333);
    check("t4_second_valid", 32'(pkt_valid), 32'd1);
    idle(1);
    pkt_ready = 1'b0;
    check("t4_empty", 32'(pkt_valid), 32'd0);

    // 5. Timeout after 4 idle cycles inside a partial packet
    do_reset();
    send(8'h08);
    idle(3);
    check("t5_no_resync_3", 32'(resync), 32'd0);
    idle(1);
    check("t5_resync_pulse", 32'(resync), 32'd1);
    idle(1);
    check("t5_resync_low", 32'(resync), 32'd0);
    check("t5_resync_once", 32'(resync_seen), 32'd1);
    send(8'h09); send(8'h11); send(8'h22);
    check("t5_pkt_valid", 32'(pkt_valid), 32'd1);
    check("t5_pkt_data", 32'(pkt_data), 32'h091122);
    check("t5_count", 32'(pkt_count), 32'd1);
    pkt_ready = 1'b1;
    idle(1);
    pkt_ready = 1'b0;
    // Byte arrives on the 4th idle cycle: accepted, no timeout
    send(8'h08);
    idle(3);
    send(8'h55);
    check("t5b_no_resync", 32'(resync), 32'd0);
    send(8'h66);
    check("t5b_valid", 32'(pkt_valid), 32'd1);
    check("t5b_data", 32'(pkt_data), 32'h085566);
    check("t5b_count", 32'(pkt_count), 32'd2);
    check("t5b_resync_total", 32'(resync_seen), 32'd1);

    // 6. Asynchronous reset between bytes 2 and 3 with one packet buffered
    do_reset();
    send(8'h08); send(8'hAB); send(8'hCD);
    send(8'h0F); send(8'h01);
    check("t6_pre_valid", 32'(pkt_valid), 32'd1);
    check("t6_pre_data", 32'(pkt_data), 32'h08ABCD);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(pkt_valid), 32'd0);
    check("t6_async_data", 32'(pkt_data), 32'd0);
    check("t6_async_count", 32'(pkt_count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    send(8'h22);
    check("t6_discard_stray", 32'(pkt_valid), 32'd0);
    send(8'h08); send(8'h77); send(8'h88);
    check("t6_valid", 32'(pkt_valid), 32'd1);
    check("t6_data", 32'(pkt_data), 32'h087788);
    check("t6_count", 32'(pkt_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_packet_ctrl.md
Name: ps2_packet_ctrl

Overview:
Controller that sequences the PS/2 mouse byte stream into 3-byte packets and hands them to a downstream consumer.
- Byte 1 is identified by bit 3 = 1.
- A stalled partial packet is abandoned after a programmable inter-byte timeout.
- Completed packets are buffered in a small FIFO with a valid/ready handshake, so the consumer may stall without losing alignment.
- Sits between the PS/2 byte deserializer and the mouse event decoder.

Parameters:
TIMEOUT_CYCLES, 255, consecutive idle cycles (no in_valid) inside a partial packet before it is discarded; legal range 1..65535.
DEPTH, 2, packet FIFO depth; power of 2, minimum 2.

Ports:
clk  input  1  single clock; all state updates on rising edge.
resetn  input  1  asynchronous, active-low reset.
in_valid  input  1  in_byte is a valid received byte this cycle.
in_byte  input  8  received byte.
pkt_valid  output  1  FIFO non-empty; pkt_data is valid.
pkt_ready  input  1  consumer accepts the head packet.
pkt_data  output  24  head packet {byte1, byte2, byte3}; byte1 in [23:16].
overflow  output  1  sticky: a completed packet was dropped because the FIFO was full.
clr_overflow  input  1  synchronous clear of overflow.
resync  output  1  one-cycle pulse: a partial packet was discarded on timeout.
pkt_count  output  16  count of packets accepted into the FIFO; wraps 0xFFFF -> 0.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FSM = SEEK; FIFO empty; idle counter = 0.
  - pkt_valid=0, pkt_data=0, overflow=0, resync=0, pkt_count=0.
  - All are held while resetn=0; reset mid-packet discards the partial packet and all buffered packets.
- FSM states: SEEK, GOT1, GOT2.
  - SEEK: in_valid & in_byte[3]=1 -> latch b1, go to GOT1. in_valid & in_byte[3]=0 -> byte discarded, stay in SEEK.
  - GOT1: in_valid -> latch b2 (bit 3 ignored), go to GOT2.
  - GOT2: in_valid -> form packet {b1,b2,in_byte}, attempt push, go to SEEK. The next byte after a packet is qualified by bit 3 again.
- Push rules:
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - On an accepted push, pkt_count increments by 1.
  - Otherwise the packet is dropped, overflow is set, and pkt_count is unchanged.
- Pop: occurs when pkt_valid & pkt_ready. The head advances at that edge.
  - Push and pop in the same cycle: both take effect; occupancy is unchanged.
- Latency:
  - pkt_valid rises on the cycle after the edge that samples byte 3 into an empty FIFO.
  - pkt_data is driven from FIFO storage (registered, no combinational path from in_byte).
  - pkt_data reads 0 whenever pkt_valid=0.
  - pkt_valid and pkt_data are stable while pkt_valid=1 and pkt_ready=0.
- Timeout:
  - The idle counter clears in SEEK and on any in_valid.
  - In GOT1/GOT2 it increments on each cycle with in_valid=0.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to SEEK at that edge, the counter clears, and resync=1 for exactly the following cycle.
  - in_valid on the cycle the count would reach TIMEOUT_CYCLES takes priority: the byte is accepted and no timeout occurs.
- overflow:
  - Set on a drop; cleared by clr_overflow=1.
  - Set wins over clear in the same cycle.
- pkt_data and pkt_count widths are fixed; there is no saturation on pkt_count.

Test Plan:
1. Basic packet: reset, then in_valid bytes 0x08, 0x12, 0x34 with pkt_ready=1 -> pkt_valid=1 for one cycle, one cycle after byte 3 is sampled; pkt_data=0x081234; pkt_count=1.
2. Alignment: bytes 0x00, 0x07, 0x0C, 0xAA, 0xBB -> first two discarded; packet 0x0CAABB; pkt_count=1; no resync.
3. Backpressure/overflow (DEPTH=2), pkt_ready=0:
   - Send 3 packets: 0x08_0102, 0x08_0304, 0x08_0506 -> pkt_valid held, pkt_data=0x080102 stable, overflow=1, pkt_count=2.
   - Then pkt_ready=1 -> 0x080102, then 0x080304; pkt_valid drops.
   - Then pulse clr_overflow -> overflow=0.
4. Full push with simultaneous pop: FIFO full, byte 3 of a new packet arrives on the same cycle as pkt_ready=1 -> no overflow, pkt_count increments, occupancy stays 2.
5. Timeout (TIMEOUT_CYCLES=4): send 0x08, then idle 4 cycles -> resync pulses once; then send 0x09, 0x11, 0x22 -> packet 0x091122. Repeat with a byte on the 4th idle cycle -> no resync, packet completes.
6. Async reset mid-packet: assert resetn=0 between bytes 2 and 3 while the FIFO holds 1 packet -> outputs zero immediately (no clock edge needed); after release, a fresh 3-byte packet is assembled correctly.
